mopshub_clk_div: RTL and testbench

// - Synchronous integer clock divider for the MOPSHUB bench and top level.
// - Derives the 40 MHz system/MOPS clocks from the 160 MHz generator clock (DIVISOR=4).
// - Registered divided clock plus a one-cycle tick strobe, both in the source clock domain.
// - Sits between the 160 MHz clock source and all mopshub_top_16bus / data-generator clock inputs.

---
 rtl/mopshub_clk_pkg.sv | 15 +
 rtl/mopshub_clk_div.sv | 70 +++++++
 tb/tb_mopshub_clk_div.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mopshub_clk_pkg.sv
// Shared constants and divisor clamp for the MOPSHUB clock divider.
package mopshub_clk_pkg;

  localparam int CNT_W_DEF = 28;

  // Ratios below 2 cannot form a high and a low phase, so they are raised to 2.
  function automatic logic [CNT_W_DEF-1:0] clamp_div(input logic [CNT_W_DEF-1:0] d);
    if (d < 28'd2) begin
      return 28'd2;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/mopshub_clk_div.sv
// Synchronous integer clock divider: registered divided clock plus first-high-cycle tick.
// Optional feature macro: MOPSHUB_CLK_DIV_RUNTIME_EN (adds div_value, reloaded at period wrap).
module mopshub_clk_div
  import mopshub_clk_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIVISOR = CNT_W'(4)
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             enable,
`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
  input  logic [CNT_W-1:0] div_value,
`endif
  output logic             clock_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(clamp_div(CNT_W_DEF'(DIVISOR)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic             clock_out_q, clock_out_d;
  logic             tick_q, tick_d;

  // Next-state: count within the period, derive clock level and tick from the count.
  always_comb begin
    cnt_d       = cnt_q;
    div_act_d   = div_act_q;
    clock_out_d = clock_out_q;
    tick_d      = 1'b0;
    if (enable) begin
      clock_out_d = (cnt_q < (div_act_q >> 1));
      tick_d      = (cnt_q == {CNT_W{1'b0}});
      if (cnt_q == (div_act_q - CNT_W'(1))) begin
        cnt_d = {CNT_W{1'b0}};
`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
        // Reload only at the wrap so every period is complete, never a runt.
        div_act_d = CNT_W'(clamp_div(CNT_W_DEF'(div_value)));
`else
        div_act_d = div_act_q;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d       = cnt_q;
      clock_out_d = clock_out_q;
    end
  end

  // State registers with synchronous reset that overrides enable.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      cnt_q       <= {CNT_W{1'b0}};
      div_act_q   <= DIV_RST;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
    end
  end

  assign clock_out = clock_out_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_mopshub_clk_div.sv
// Self-checking bench: several divider instances against a period-position reference model.
`timescale 1ps/1ps
module tb_mopshub_clk_div;

  localparam int N = 6;
  localparam int DV [N] = '{4, 5, 0, 1, 3, 7};

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
  logic [27:0]   div_value = 28'd4;
`endif
  logic          co_s [N];
  logic          tk_s [N];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;

  // reference model: position inside the current period and active ratio
  int            m_pos  [N];
  int            m_dact [N];
  logic          m_co   [N];
  logic          m_tk   [N];

  logic          meas_en = 1'b0;
  time           rise_t [$];

  always #3125 clk = ~clk;   // 160 MHz

  for (genvar g = 0; g < N; g++) begin : g_dut
    mopshub_clk_div #(.CNT_W(28), .DIVISOR(28'(DV[g]))) u_dut (
      .clock_in  (clk),
      .rst       (rst),
      .enable    (enable),
`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
      .div_value (div_value),
`endif
      .clock_out (co_s[g]),
      .tick      (tk_s[g])
    );
  end

  always @(posedge co_s[0]) begin
    if (meas_en) rise_t.push_back($time);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int clampi(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  // High for the first floor(D/2) positions of a D-long period; tick at position 0.
  task automatic model_update(input logic r, input logic e);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_pos[i]  = 0;
        m_co[i]   = 1'b0;
        m_tk[i]   = 1'b0;
        m_dact[i] = clampi(DV[i]);
      end else if (e) begin
        m_co[i] = (m_pos[i] < m_dact[i] / 2);
        m_tk[i] = (m_pos[i] == 0);
        if (m_pos[i] == m_dact[i] - 1) begin
`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
          m_dact[i] = clampi(int'(div_value));
`endif
          m_pos[i] = 0;
        end else begin
          m_pos[i] = (m_pos[i] + 1) % m_dact[i];
        end
      end else begin
        m_tk[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e);
    rst    = r;
    enable = e;
    @(posedge clk);
    model_update(r, e);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("clock_out_D%0d", DV[i]), 64'(co_s[i]), 64'(m_co[i]));
      check_eq($sformatf("tick_D%0d", DV[i]), 64'(tk_s[i]), 64'(m_tk[i]));
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;

    // reset state, then free-running with period measurement
    step(1'b1, 1'b1);
    meas_en = 1'b1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    meas_en = 1'b0;
    check_eq("rise_count_ge2", 64'(rise_t.size() >= 2), 64'd1);
    if (rise_t.size() >= 2) begin
      check_eq("period_ps_D4", 64'(rise_t[1] - rise_t[0]), 64'd25000);
    end else begin
      check_eq("period_ps_D4", 64'd0, 64'd25000);
    end

    // freeze after the second high cycle
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1);

    // single-cycle reset mid-period
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);

`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
    // ratio change mid-period takes effect at the next period
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    div_value = 28'd8;
    for (int k = 0; k < 26; k++) step(1'b0, 1'b1);
`endif

    // randomized run
    for (int k = 0; k < 500; k++) begin
`ifdef MOPSHUB_CLK_DIV_RUNTIME_EN
      if ($urandom_range(0, 15) == 0) div_value = 28'($urandom_range(0, 9));
`endif
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
